bit_pattern_sequencer: RTL and testbench

- Pattern playback engine downstream of the clock divider stage.
- Consumes a one-cycle `tick` enable on the system clock (not the divided clock itself) and steps through a pattern RAM of configurable depth.
- Drives one WIDTH-bit pattern word per tick period on `pattern_out`, for a programmed number of passes or indefinitely.

---
 rtl/bit_pattern_sequencer_if.sv | 28 ++
 rtl/bit_pattern_sequencer.sv | 147 ++++++++++++++
 tb/tb_bit_pattern_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_pattern_sequencer_if.sv
// Bus bundle between the pattern sequencer, its controller and its pattern RAM.
// The master side drives control, configuration and RAM read data; the slave is the sequencer.
interface bit_pattern_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 10
);
    logic             tick;
    logic             start;
    logic             stop;
    logic [AW:0]      depth;
    logic [15:0]      repeat_count;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] pattern_out;
    logic             running;
    logic             done;
    logic             overrun;

    modport master (
        output tick, start, stop, depth, repeat_count, mem_data,
        input  mem_addr, pattern_out, running, done, overrun
    );

    modport slave (
        input  tick, start, stop, depth, repeat_count, mem_data,
        output mem_addr, pattern_out, running, done, overrun
    );
endinterface

// File: rtl/bit_pattern_sequencer.sv
// Pattern playback engine: steps through a pattern RAM one word per tick,
// for a programmed number of passes or forever, using a one-word prefetch
// to hide the RAM read latency.
module bit_pattern_sequencer #(
    parameter int               WIDTH     = 16,
    parameter int               AW        = 10,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input logic                    clk,
    input logic                    reset,
    bit_pattern_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    localparam logic [AW:0] DEPTH_MAX = {1'b1, {AW{1'b0}}};

    state_t           state_q;
    logic             prime_phase_q;
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    word_q;
    logic [AW:0]      depth_q;
    logic [15:0]      repeat_q;
    logic [15:0]      pass_q;
    logic [WIDTH-1:0] prefetch_q;
    logic [WIDTH-1:0] pattern_q;
    logic             pf_valid_q;
    logic             refill_q;
    logic             last_emitted_q;
    logic             running_q;
    logic             done_q;
    logic             overrun_q;

    logic [AW-1:0]    word_d;
    logic             is_last_word;
    logic             final_pass;
    logic             advance_addr;
    logic             start_ok;

    // Index bookkeeping: wrap point, final-pass detection and whether the RAM address should move on
    always_comb begin
        is_last_word = ({1'b0, word_q} == (depth_q - 1'b1));
        word_d       = is_last_word ? '0 : word_q + 1'b1;
        final_pass   = (repeat_q != 16'd0) && (pass_q == (repeat_q - 16'd1));
        advance_addr = !last_emitted_q && !(is_last_word && final_pass);
        start_ok     = bus.start && (bus.depth != '0) && (bus.depth <= DEPTH_MAX);
    end

    // Control FSM with all outputs registered; stop overrides everything but reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            prime_phase_q  <= 1'b0;
            addr_q         <= '0;
            word_q         <= '0;
            depth_q        <= '0;
            repeat_q       <= '0;
            pass_q         <= '0;
            prefetch_q     <= '0;
            pattern_q      <= IDLE_WORD;
            pf_valid_q     <= 1'b0;
            refill_q       <= 1'b0;
            last_emitted_q <= 1'b0;
            running_q      <= 1'b0;
            done_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                state_q        <= IDLE;
                prime_phase_q  <= 1'b0;
                pattern_q      <= IDLE_WORD;
                running_q      <= 1'b0;
                pf_valid_q     <= 1'b0;
                refill_q       <= 1'b0;
                last_emitted_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_ok) begin
                            state_q        <= PRIME;
                            prime_phase_q  <= 1'b0;
                            depth_q        <= bus.depth;
                            repeat_q       <= bus.repeat_count;
                            addr_q         <= '0;
                            word_q         <= '0;
                            pass_q         <= '0;
                            pf_valid_q     <= 1'b0;
                            refill_q       <= 1'b0;
                            last_emitted_q <= 1'b0;
                            overrun_q      <= 1'b0;
                            running_q      <= 1'b1;
                        end
                    end
                    PRIME: begin
                        if (!prime_phase_q) begin
                            prime_phase_q <= 1'b1;
                        end else begin
                            prime_phase_q <= 1'b0;
                            prefetch_q    <= bus.mem_data;
                            pf_valid_q    <= 1'b1;
                            if (advance_addr) addr_q <= word_d;
                            state_q       <= RUN;
                        end
                    end
                    RUN: begin
                        if (refill_q) begin
                            refill_q   <= 1'b0;
                            prefetch_q <= bus.mem_data;
                            pf_valid_q <= 1'b1;
                            if (advance_addr) addr_q <= word_d;
                        end
                        if (bus.tick) begin
                            if (!pf_valid_q) begin
                                overrun_q <= 1'b1;
                            end else if (last_emitted_q) begin
                                state_q        <= IDLE;
                                pattern_q      <= IDLE_WORD;
                                done_q         <= 1'b1;
                                running_q      <= 1'b0;
                                pf_valid_q     <= 1'b0;
                                last_emitted_q <= 1'b0;
                            end else begin
                                pattern_q  <= prefetch_q;
                                pf_valid_q <= 1'b0;
                                refill_q   <= 1'b1;
                                word_q     <= word_d;
                                if (is_last_word) begin
                                    if (pass_q != 16'hFFFF) pass_q <= pass_q + 16'd1;
                                    if (final_pass) last_emitted_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.mem_addr    = addr_q;
    assign bus.pattern_out = pattern_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_bit_pattern_sequencer.sv
// Directed bench for bit_pattern_sequencer: a RAM model feeds the DUT and
// expected pattern words are queued when a run is started and popped per tick.
module tb_bit_pattern_sequencer;

    localparam int WIDTH = 16;
    localparam int AW    = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bit_pattern_sequencer_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    bit_pattern_sequencer #(
        .WIDTH(WIDTH),
        .AW(AW),
        .IDLE_WORD(16'h0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [WIDTH-1:0] ram [0:(1<<AW)-1];
    logic [WIDTH-1:0] expQ [$];
    int               vectors = 0;
    int               miscompares = 0;
    int               wrapCount = 0;
    int               doneCount = 0;
    logic [AW-1:0]    lastAddr = '0;

    // Synchronous-read RAM model: data appears one clock after the address
    always @(posedge clk) bus.mem_data <= ram[bus.mem_addr];

    // Monitor counting done pulses and 2->0 address wraps while out of reset
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (lastAddr == 10'd2 && bus.mem_addr == 10'd0) wrapCount++;
            if (bus.done === 1'b1) doneCount++;
        end
        lastAddr = bus.mem_addr;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input int dp, input int rp);
        bus.start        = st;
        bus.stop         = sp;
        bus.depth        = 11'(dp);
        bus.repeat_count = 16'(rp);
        cycle();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic pushPattern(input int dp, input int passes);
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < dp; i++)
                expQ.push_back(ram[i]);
        expQ.push_back(16'h0000);
    endtask

    task automatic applyTick(input string tag, input int gap);
        logic [WIDTH-1:0] expWord;
        bus.tick = 1'b1;
        cycle();
        bus.tick = 1'b0;
        if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s: observed empty expectation queue expected an entry", tag);
        end else begin
            expWord = expQ.pop_front();
            checkOutput(tag, 32'(bus.pattern_out), 32'(expWord));
        end
        for (int g = 1; g < gap; g++) cycle();
    endtask

    initial begin
        int doneBase;
        reset            = 1'b0;
        bus.tick         = 1'b0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.depth        = '0;
        bus.repeat_count = '0;
        cycle();
        cycle();
        checkOutput("rst_pattern", 32'(bus.pattern_out), 32'h0);
        checkOutput("rst_running", 32'(bus.running), 32'h0);
        checkOutput("rst_done", 32'(bus.done), 32'h0);
        checkOutput("rst_overrun", 32'(bus.overrun), 32'h0);
        checkOutput("rst_addr", 32'(bus.mem_addr), 32'h0);
        reset = 1'b1;
        cycle();

        // Single pass of four words, tick every 4 cycles, with a tick during priming
        $display("[TB] depth 4, one pass");
        ram[0] = 16'h00A1; ram[1] = 16'h00B2; ram[2] = 16'h00C3; ram[3] = 16'h00D4;
        applyStimulus(1'b1, 1'b0, 4, 1);
        checkOutput("t1_running", 32'(bus.running), 32'h1);
        pushPattern(4, 1);
        bus.tick = 1'b1;
        cycle();
        bus.tick = 1'b0;
        cycle();
        checkOutput("t1_prime_tick", 32'(bus.pattern_out), 32'h0);
        for (int k = 0; k < 4; k++) applyTick("t1_word", 4);
        applyTick("t1_end", 1);
        checkOutput("t1_done", 32'(bus.done), 32'h1);
        checkOutput("t1_running_low", 32'(bus.running), 32'h0);
        checkOutput("t1_overrun", 32'(bus.overrun), 32'h0);
        cycle();
        checkOutput("t1_done_pulse", 32'(bus.done), 32'h0);

        // Two passes of three words: exactly one address wrap between passes
        $display("[TB] depth 3, two passes");
        ram[0] = 16'h0A10; ram[1] = 16'h0A11; ram[2] = 16'h0A12;
        applyStimulus(1'b1, 1'b0, 3, 2);
        wrapCount = 0;
        doneBase  = doneCount;
        cycle();
        cycle();
        pushPattern(3, 2);
        for (int k = 0; k < 6; k++) applyTick("t2_word", 3);
        applyTick("t2_end", 1);
        cycle();
        checkOutput("t2_wraps", 32'(wrapCount), 32'd1);
        checkOutput("t2_dones", 32'(doneCount - doneBase), 32'd1);

        // Infinite repeat at minimum tick spacing, then stop
        $display("[TB] depth 2, infinite");
        ram[0] = 16'h55AA; ram[1] = 16'hAA55;
        applyStimulus(1'b1, 1'b0, 2, 0);
        doneBase = doneCount;
        cycle();
        cycle();
        for (int k = 0; k < 50; k++) expQ.push_back(ram[k % 2]);
        for (int k = 0; k < 50; k++) applyTick("t3_word", 2);
        checkOutput("t3_no_done", 32'(doneCount - doneBase), 32'd0);
        checkOutput("t3_overrun", 32'(bus.overrun), 32'h0);
        applyStimulus(1'b0, 1'b1, 2, 0);
        checkOutput("t3_stop_pattern", 32'(bus.pattern_out), 32'h0);
        checkOutput("t3_stop_running", 32'(bus.running), 32'h0);
        checkOutput("t3_stop_done", 32'(bus.done), 32'h0);

        // Back-to-back ticks: second is dropped and overrun sticks until a new start
        $display("[TB] overrun");
        ram[0] = 16'h00A1; ram[1] = 16'h00B2; ram[2] = 16'h00C3; ram[3] = 16'h00D4;
        applyStimulus(1'b1, 1'b0, 4, 0);
        cycle();
        cycle();
        expQ.push_back(16'h00A1);
        expQ.push_back(16'h00A1);
        expQ.push_back(16'h00B2);
        applyTick("t4_first", 1);
        applyTick("t4_dropped", 4);
        checkOutput("t4_overrun_set", 32'(bus.overrun), 32'h1);
        applyTick("t4_next", 4);
        checkOutput("t4_overrun_held", 32'(bus.overrun), 32'h1);
        applyStimulus(1'b0, 1'b1, 4, 0);
        checkOutput("t4_overrun_idle", 32'(bus.overrun), 32'h1);
        applyStimulus(1'b1, 1'b0, 4, 1);
        checkOutput("t4_overrun_clr", 32'(bus.overrun), 32'h0);
        checkOutput("t4_restart", 32'(bus.running), 32'h1);
        applyStimulus(1'b0, 1'b1, 4, 1);

        // Rejected starts and ticks while idle
        $display("[TB] rejected starts");
        applyStimulus(1'b1, 1'b0, 0, 1);
        checkOutput("t5_depth0", 32'(bus.running), 32'h0);
        cycle();
        cycle();
        checkOutput("t5_depth0_late", 32'(bus.running), 32'h0);
        applyStimulus(1'b1, 1'b0, 1025, 1);
        checkOutput("t5_depth_big", 32'(bus.running), 32'h0);
        applyStimulus(1'b1, 1'b1, 4, 1);
        checkOutput("t5_start_stop", 32'(bus.running), 32'h0);
        bus.tick = 1'b1;
        cycle();
        bus.tick = 1'b0;
        checkOutput("t5_idle_tick", 32'(bus.pattern_out), 32'h0);
        checkOutput("t5_idle_overrun", 32'(bus.overrun), 32'h0);

        // Reset mid-run, then a fresh run replays from address 0
        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 1'b0, 4, 0);
        cycle();
        cycle();
        expQ.push_back(16'h00A1);
        expQ.push_back(16'h00A1);
        expQ.push_back(16'h00B2);
        applyTick("t6_a", 1);
        applyTick("t6_drop", 4);
        applyTick("t6_b", 2);
        reset = 1'b0;
        cycle();
        checkOutput("t6_rst_pattern", 32'(bus.pattern_out), 32'h0);
        checkOutput("t6_rst_running", 32'(bus.running), 32'h0);
        checkOutput("t6_rst_done", 32'(bus.done), 32'h0);
        checkOutput("t6_rst_overrun", 32'(bus.overrun), 32'h0);
        checkOutput("t6_rst_addr", 32'(bus.mem_addr), 32'h0);
        reset = 1'b1;
        cycle();
        applyStimulus(1'b1, 1'b0, 4, 1);
        cycle();
        cycle();
        pushPattern(4, 1);
        for (int k = 0; k < 4; k++) applyTick("t6_replay", 4);
        applyTick("t6_end", 1);
        checkOutput("t6_done", 32'(bus.done), 32'h1);

        // Depth 1 re-emits one word; a start in the done cycle is accepted
        $display("[TB] depth 1");
        ram[0] = 16'h7E7E;
        cycle();
        applyStimulus(1'b1, 1'b0, 1, 2);
        cycle();
        cycle();
        pushPattern(1, 2);
        applyTick("t7_word", 4);
        checkOutput("t7_addr", 32'(bus.mem_addr), 32'h0);
        applyTick("t7_word", 4);
        checkOutput("t7_addr", 32'(bus.mem_addr), 32'h0);
        applyTick("t7_end", 1);
        checkOutput("t7_done", 32'(bus.done), 32'h1);
        applyStimulus(1'b1, 1'b0, 1, 1);
        checkOutput("t7_start_on_done", 32'(bus.running), 32'h1);
        cycle();
        cycle();
        pushPattern(1, 1);
        applyTick("t7_again", 4);
        applyTick("t7_again_end", 1);
        checkOutput("t7_again_done", 32'(bus.done), 32'h1);

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
